lc3b_pipe_ctrl: RTL and testbench
=================================

# lc3b_pipe_ctrl

Pipeline sequencing controller for the five-stage LC-3b core (FETCH, DECODE, AGEX, MEM, SR). It drives the load and bubble strobes of every inter-stage latch group: IR1 (decode), IR2 (agex, all `load_agex_*` tied to `load_agex`), MEM and SR. It owns the data-memory access FSM, including the two-access LDI/STI sequence. It resolves memory stalls, taken-branch flushes, decode dependency stalls and instruction-fetch stalls under a fixed priority.

## Interface
- No parameters.
- clk  in  1  core clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- imem_resp  in  1  instruction memory has valid data this cycle
- mem_valid  in  1  MEM latch holds a real (non-bubble) instruction
- mem_req  in  1  instruction in MEM needs data memory (LD*, ST*, LEA excluded)
- mem_indirect  in  1  instruction in MEM is LDI/STI (two accesses)
- dmem_resp  in  1  data memory completed the current access
- br_taken  in  1  MEM resolved a taken branch/JMP/JSR/TRAP this cycle
- dep_stall  in  1  DECODE source register matches an in-flight DR
- load_pc, load_de, load_agex, load_mem, load_sr  out  1 each  latch enables
- squash_de, bubble_agex, bubble_mem, bubble_sr  out  1 each  load a NOP/zero control word instead of upstream data
- dmem_strobe  out  1  data memory request active
- dmem_phase  out  1  0 = first/only access, 1 = second access of LDI/STI
- stall_cnt, flush_cnt  out  16 each  perf counters (see Configuration)

## Operation
- Mem FSM states: IDLE, ACC1, ACC2, DONE.
  - IDLE → ACC1 when mem_valid & mem_req.
  - ACC1 (strobe=1, phase=0): on dmem_resp → ACC2 if mem_indirect, else DONE.
  - ACC2 (strobe=1, phase=1): on dmem_resp → DONE.
  - DONE (strobe=0): unconditional → IDLE.
- mem_busy = (IDLE & mem_valid & mem_req) | ACC1 | ACC2. DONE is not busy.
- Priority: mem_busy > br_taken > dep_stall > !imem_resp > run. Exactly one case applies per cycle.
- mem_busy: load_pc/de/agex/mem = 0; load_sr=1, bubble_sr=1. br_taken is ignored while busy.
- br_taken: load_pc=1; load_de=1 with squash_de; load_agex=1 with bubble_agex; load_mem=1 with bubble_mem; load_sr=1 (branch instruction retires normally).
- dep_stall: load_pc=0, load_de=0; load_agex=1 with bubble_agex; load_mem=1, load_sr=1.
- !imem_resp: load_pc=0; load_de=1 with squash_de; agex/mem/sr load normally.
- run: all five loads 1, all bubbles 0.
- Bubble/squash outputs are 0 whenever the matching load is 0.

## Timing
- All strobes are combinational from FSM state and inputs; the only sequential state is the FSM and the counters.
- Reset (reset_n low, asynchronous): FSM=IDLE, counters=0. All load, bubble and squash outputs are 0 and dmem_strobe=0 while reset is held.
- Reset asserted mid-access: dmem_strobe drops in the same cycle; the access is abandoned.
- Plain load/store with dmem_resp in the first ACC1 cycle occupies MEM for 3 cycles (IDLE-busy, ACC1, DONE). Each extra wait cycle adds 1. LDI/STI adds at least 1 more cycle (ACC2).
- dmem_resp in IDLE or DONE is ignored.
- mem_indirect is sampled only in ACC1 on the dmem_resp cycle.
- A branch whose br_taken coincides with mem_busy is honoured on the first non-busy cycle, provided br_taken is still asserted.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cnt increments on every cycle in which load_pc=0 and reset_n=1.
  - flush_cnt increments on every cycle in which the br_taken case applies.
  - Both counters saturate at 0xFFFF.
- Not defined: stall_cnt and flush_cnt are tied to 0 and no counter flops exist.

## Test plan
- Reset with mem_valid=1 and mem_req=1 held → all loads 0 and dmem_strobe=0 during reset. After release: cycle 0 busy, cycle 1 dmem_strobe=1 with phase=0.
- LDR with dmem_resp two cycles into ACC1 → load_mem=0 for exactly 4 cycles, load_sr=1 with bubble_sr=1 each of those cycles, then a DONE cycle with all loads 1.
- LDI with resp on the first cycle of both ACC1 and ACC2 → phase sequence 0 then 1; dmem_strobe high for 2 cycles; DONE on the 4th cycle.
- br_taken=1 and dep_stall=1 together, FSM idle → load_pc=1, squash_de=1, bubble_agex=1, bubble_mem=1; flush_cnt goes 0→1 with PIPE_CTRL_PERF_EN defined.
- dep_stall=1 for 2 cycles → load_pc=0 and load_de=0 for 2 cycles, bubble_agex=1 on both; stall_cnt=2.
- imem_resp=0 for 3 cycles in run → load_pc=0 and squash_de=1 for 3 cycles; load_agex, load_mem, load_sr stay 1.

Source files
------------

// File: rtl/lc3b_pipe_ctrl.sv
// lc3b_pipe_ctrl: pipeline sequencing controller for the five-stage LC-3b core.
// Drives the latch-group load/bubble strobes and owns the data-memory access
// FSM, including the two-access LDI/STI sequence.
// Optional feature macro: PIPE_CTRL_PERF_EN enables the stall/flush counters.
module lc3b_pipe_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        imem_resp,
  input  logic        mem_valid,
  input  logic        mem_req,
  input  logic        mem_indirect,
  input  logic        dmem_resp,
  input  logic        br_taken,
  input  logic        dep_stall,
  output logic        load_pc,
  output logic        load_de,
  output logic        load_agex,
  output logic        load_mem,
  output logic        load_sr,
  output logic        squash_de,
  output logic        bubble_agex,
  output logic        bubble_mem,
  output logic        bubble_sr,
  output logic        dmem_strobe,
  output logic        dmem_phase,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} mem_state_e;

  mem_state_e state_q, state_d;
  logic       mem_busy;
  logic       flush_case;

  // Mem FSM state register; async reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Mem FSM next state and data-memory strobes.
  always_comb begin
    state_d     = state_q;
    dmem_strobe = 1'b0;
    dmem_phase  = 1'b0;
    unique case (state_q)
      IDLE: if (mem_valid && mem_req) state_d = ACC1;
      ACC1: begin
        dmem_strobe = reset_n;
        if (dmem_resp) state_d = mem_indirect ? ACC2 : DONE;
      end
      ACC2: begin
        dmem_strobe = reset_n;
        dmem_phase  = reset_n;
        if (dmem_resp) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The IDLE cycle that launches an access is already busy so MEM holds.
  assign mem_busy = ((state_q == IDLE) && mem_valid && mem_req) ||
                    (state_q == ACC1) || (state_q == ACC2);

  // Fixed-priority hazard resolution: mem > branch > dependency > fetch > run.
  always_comb begin
    load_pc     = 1'b0;
    load_de     = 1'b0;
    load_agex   = 1'b0;
    load_mem    = 1'b0;
    load_sr     = 1'b0;
    squash_de   = 1'b0;
    bubble_agex = 1'b0;
    bubble_mem  = 1'b0;
    bubble_sr   = 1'b0;
    flush_case  = 1'b0;
    if (reset_n) begin
      if (mem_busy) begin
        load_sr   = 1'b1;
        bubble_sr = 1'b1;
      end else if (br_taken) begin
        flush_case  = 1'b1;
        load_pc     = 1'b1;
        load_de     = 1'b1;
        squash_de   = 1'b1;
        load_agex   = 1'b1;
        bubble_agex = 1'b1;
        load_mem    = 1'b1;
        bubble_mem  = 1'b1;
        load_sr     = 1'b1;
      end else if (dep_stall) begin
        load_agex   = 1'b1;
        bubble_agex = 1'b1;
        load_mem    = 1'b1;
        load_sr     = 1'b1;
      end else if (!imem_resp) begin
        load_de   = 1'b1;
        squash_de = 1'b1;
        load_agex = 1'b1;
        load_mem  = 1'b1;
        load_sr   = 1'b1;
      end else begin
        load_pc   = 1'b1;
        load_de   = 1'b1;
        load_agex = 1'b1;
        load_mem  = 1'b1;
        load_sr   = 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_q, flush_q;

  // Saturating perf counters: fetch-stalled cycles and branch flushes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!load_pc && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (flush_case && (flush_q != 16'hFFFF)) flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 16'd0;
  assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_lc3b_pipe_ctrl.sv
// Bench for lc3b_pipe_ctrl: directed scenarios plus a randomized run, checked
// against a transaction-level model (access count, done flag, priority pick).
module tb_lc3b_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_resp = 1'b1, mem_valid = 1'b0, mem_req = 1'b0, mem_indirect = 1'b0;
  logic        dmem_resp = 1'b0, br_taken = 1'b0, dep_stall = 1'b0;
  logic        load_pc, load_de, load_agex, load_mem, load_sr;
  logic        squash_de, bubble_agex, bubble_mem, bubble_sr, dmem_strobe, dmem_phase;
  logic [15:0] stall_cnt, flush_cnt;

  lc3b_pipe_ctrl dut (
    .clk(clk), .reset_n(reset_n), .imem_resp(imem_resp), .mem_valid(mem_valid),
    .mem_req(mem_req), .mem_indirect(mem_indirect), .dmem_resp(dmem_resp),
    .br_taken(br_taken), .dep_stall(dep_stall),
    .load_pc(load_pc), .load_de(load_de), .load_agex(load_agex), .load_mem(load_mem),
    .load_sr(load_sr), .squash_de(squash_de), .bubble_agex(bubble_agex),
    .bubble_mem(bubble_mem), .bubble_sr(bubble_sr), .dmem_strobe(dmem_strobe),
    .dmem_phase(dmem_phase), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // {load_pc,load_de,load_agex,load_mem,load_sr,squash_de,bubble_agex,bubble_mem,bubble_sr,strobe,phase}
  wire [10:0] outs = {load_pc, load_de, load_agex, load_mem, load_sr, squash_de,
                      bubble_agex, bubble_mem, bubble_sr, dmem_strobe, dmem_phase};

  int n_cmp = 0;
  int n_bad = 0;

  // Model: accesses_left counts outstanding data accesses of the MEM op
  // (0 = none in flight), acc_no which access we are on, done_gap the one
  // post-access cycle in which a new request is not yet accepted.
  int   accesses_left = 0;
  int   acc_no = 0;
  bit   done_gap = 0;
  int   m_stall = 0, m_flush = 0;
  logic [10:0] exp_outs;
  logic [15:0] exp_stall, exp_flush;

  // Apply one cycle of inputs, compute model expectations, advance the model.
  task automatic drive(input bit rn, input bit ir, input bit mv, input bit mr,
                       input bit mi, input bit dr, input bit bt, input bit ds);
    bit busy, in_acc;
    @(negedge clk);
    reset_n = rn; imem_resp = ir; mem_valid = mv; mem_req = mr;
    mem_indirect = mi; dmem_resp = dr; br_taken = bt; dep_stall = ds;
    #1;
    if (!rn) begin
      accesses_left = 0; acc_no = 0; done_gap = 0; m_stall = 0; m_flush = 0;
      exp_outs = '0; exp_stall = '0; exp_flush = '0;
    end else begin
      in_acc = (accesses_left > 0);
      busy   = in_acc || (!done_gap && mv && mr);
      if (busy)     exp_outs = 11'b00001_0001_00;
      else if (bt)  exp_outs = 11'b11111_1110_00;
      else if (ds)  exp_outs = 11'b00111_0100_00;
      else if (!ir) exp_outs = 11'b01111_1000_00;
      else          exp_outs = 11'b11111_0000_00;
      exp_outs[1] = in_acc;
      exp_outs[0] = in_acc && (acc_no == 2);
`ifdef PIPE_CTRL_PERF_EN
      exp_stall = m_stall[15:0];
      exp_flush = m_flush[15:0];
`else
      exp_stall = '0;
      exp_flush = '0;
`endif
      if (!exp_outs[10] && m_stall < 65535) m_stall++;
      if (!busy && bt && m_flush < 65535) m_flush++;
      if (done_gap) done_gap = 0;
      else if (in_acc) begin
        if (dr) begin
          if (acc_no == 1 && mi) acc_no = 2;
          else begin accesses_left = 0; done_gap = 1; end
        end
      end else if (mv && mr) begin
        accesses_left = 1; acc_no = 1;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 1, 1, 0, 0, 0, 0);
      n_cmp++;
      if (outs !== 11'b0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
        n_bad++;
        $display("FAIL reset_hold outs got %b want 0, cnt %0d/%0d want 0/0", outs, stall_cnt, flush_cnt);
      end
    end
    drive(1, 1, 1, 1, 0, 0, 0, 0);
    n_cmp++;
    if (outs !== 11'b00001_0001_00) begin
      n_bad++; $display("FAIL reset_rel_c0 outs got %b want %b", outs, 11'b00001_0001_00);
    end
    drive(1, 1, 1, 1, 0, 1, 0, 0);
    n_cmp++;
    if (outs !== 11'b00001_0001_10) begin
      n_bad++; $display("FAIL reset_rel_c1 outs got %b want %b", outs, 11'b00001_0001_10);
    end
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (outs !== exp_outs || stall_cnt !== exp_stall) begin
      n_bad++; $display("FAIL reset_done outs got %b want %b stall %0d want %0d", outs, exp_outs, stall_cnt, exp_stall);
    end
    drive(1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_ldr();
    int held = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1, 1, 1, 1, 0, (c == 3), 0, 0);
      if (!load_mem) held++;
      n_cmp++;
      if (outs !== exp_outs || stall_cnt !== exp_stall) begin
        n_bad++; $display("FAIL ldr_c%0d outs got %b want %b stall %0d want %0d", c, outs, exp_outs, stall_cnt, exp_stall);
      end
      if (c < 4 && !(load_sr && bubble_sr)) begin
        n_bad++; $display("FAIL ldr_sr_bubble_c%0d got sr=%b bub=%b want 1/1", c, load_sr, bubble_sr);
      end
    end
    n_cmp++;
    if (held !== 4 || outs[10:6] !== 5'b11111) begin
      n_bad++; $display("FAIL ldr_hold got %0d cycles loads=%b want 4 cycles loads=11111", held, outs[10:6]);
    end
    drive(1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_ldi();
    int strobes = 0;
    logic [1:0] phases;
    phases = '0;
    for (int c = 0; c < 4; c++) begin
      drive(1, 1, 1, 1, 1, (c == 1 || c == 2), 0, 0);
      if (dmem_strobe) strobes++;
      if (c == 1) phases[0] = dmem_phase;
      if (c == 2) phases[1] = dmem_phase;
      n_cmp++;
      if (outs !== exp_outs) begin
        n_bad++; $display("FAIL ldi_c%0d outs got %b want %b", c, outs, exp_outs);
      end
    end
    n_cmp++;
    if (strobes !== 2 || phases !== 2'b10 || outs !== 11'b11111_0000_00) begin
      n_bad++; $display("FAIL ldi_seq got strobes=%0d phases=%b outs=%b want 2/10/11111000000", strobes, phases, outs);
    end
    drive(1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_br_dep();
    logic [15:0] f0;
    drive(1, 1, 0, 0, 0, 0, 1, 1);
    f0 = flush_cnt;
    n_cmp++;
    if (outs !== 11'b11111_1110_00 || flush_cnt !== exp_flush) begin
      n_bad++; $display("FAIL br_dep outs got %b want 11111111000 flush %0d want %0d", outs, flush_cnt, exp_flush);
    end
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    n_cmp++;
`ifdef PIPE_CTRL_PERF_EN
    if (flush_cnt !== f0 + 16'd1) begin
      n_bad++; $display("FAIL br_flush_cnt got %0d want %0d", flush_cnt, f0 + 16'd1);
    end
`else
    if (flush_cnt !== 16'd0) begin
      n_bad++; $display("FAIL br_flush_cnt got %0d want 0", flush_cnt);
    end
`endif
  endtask

  task automatic test_dep();
    logic [15:0] s0;
    s0 = stall_cnt;
    for (int c = 0; c < 2; c++) begin
      drive(1, 1, 0, 0, 0, 0, 0, 1);
      if (c == 0) s0 = stall_cnt;
      n_cmp++;
      if (outs !== 11'b00111_0100_00 || stall_cnt !== exp_stall) begin
        n_bad++; $display("FAIL dep_c%0d outs got %b want 00111010000 stall %0d want %0d", c, outs, stall_cnt, exp_stall);
      end
    end
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    n_cmp++;
`ifdef PIPE_CTRL_PERF_EN
    if (stall_cnt !== s0 + 16'd2) begin
      n_bad++; $display("FAIL dep_stall_cnt got %0d want %0d", stall_cnt, s0 + 16'd2);
    end
`else
    if (stall_cnt !== 16'd0) begin
      n_bad++; $display("FAIL dep_stall_cnt got %0d want 0", stall_cnt);
    end
`endif
  endtask

  task automatic test_imem();
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (outs !== 11'b01111_1000_00 || stall_cnt !== exp_stall) begin
        n_bad++; $display("FAIL imem_c%0d outs got %b want 01111100000 stall %0d want %0d", c, outs, stall_cnt, exp_stall);
      end
    end
    drive(1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 1, 1, 1, 0, 0, 0);
    drive(1, 1, 1, 1, 1, 0, 0, 0);
    n_cmp++;
    if (dmem_strobe !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_pre strobe got %b want 1", dmem_strobe);
    end
    drive(0, 1, 1, 1, 1, 0, 0, 0);
    n_cmp++;
    if (outs !== 11'b0 || stall_cnt !== 16'd0) begin
      n_bad++; $display("FAIL rst_mid outs got %b want 0 stall %0d want 0", outs, stall_cnt);
    end
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (outs !== 11'b11111_0000_00) begin
      n_bad++; $display("FAIL rst_mid_after outs got %b want 11111000000", outs);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 1) == 0), ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
      n_cmp++;
      if (outs !== exp_outs || stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
        n_bad++;
        $display("FAIL rand_c%0d outs got %b want %b stall %0d/%0d flush %0d/%0d",
                 c, outs, exp_outs, stall_cnt, exp_stall, flush_cnt, exp_flush);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ldr();
    test_ldi();
    test_br_dep();
    test_dep();
    test_imem();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
